// File: rtl/pid_chn_scheduler_pkg.sv
// Shared constants and helpers for the PID channel scheduler.
package pid_chn_scheduler_pkg;

    localparam int unsigned DEF_NUM_CHN    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    // Channel index width; a single-channel build still carries a 1-bit index.
    function automatic int unsigned chn_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pid_chn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping to 0.
module pid_chn_scheduler_rr_arbiter
    import pid_chn_scheduler_pkg::*;
#(
    parameter  int unsigned N  = DEF_NUM_CHN,
    localparam int unsigned IW = chn_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_oh_c,
    output logic [IW-1:0] gnt_idx_c,
    output logic          gnt_any_c
);

    // Walk the request vector starting at ptr; the first hit wins.
    always_comb begin
        int unsigned pos;
        logic [IW-1:0] idx;
        gnt_oh_c  = '0;
        gnt_idx_c = '0;
        gnt_any_c = 1'b0;
        pos       = 0;
        idx       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(ptr_i) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IW'(pos);
            if (!gnt_any_c && req_i[idx]) begin
                gnt_any_c      = 1'b1;
                gnt_oh_c[idx]  = 1'b1;
                gnt_idx_c      = idx;
            end
        end
    end

endmodule

// File: rtl/pid_chn_scheduler.sv
// N-channel front end for the shared PID core: latches feedback and setpoints,
// round-robins pending samples onto a valid/ready port, tracks overrun and staleness.
module pid_chn_scheduler
    import pid_chn_scheduler_pkg::*;
#(
    parameter  int unsigned NUM_CHN        = DEF_NUM_CHN,
    parameter  int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter  int unsigned TIMEOUT_CYCLES = 1000000,
    localparam int unsigned CHN_WIDTH      = chn_width(NUM_CHN)
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [NUM_CHN-1:0]            rpm_valid_i,
    input  logic [NUM_CHN*DATA_WIDTH-1:0] rpm_data_i,
    input  logic                          tr_valid_i,
    input  logic [CHN_WIDTH-1:0]          tr_chn_i,
    input  logic [DATA_WIDTH-1:0]         tr_data_i,
    input  logic [NUM_CHN-1:0]            chn_en_i,
    input  logic                          tready_i,
    output logic                          data_valid_o,
    output logic [CHN_WIDTH-1:0]          data_chn_o,
    output logic [DATA_WIDTH-1:0]         data_fdb_o,
    output logic [DATA_WIDTH-1:0]         data_ref_o,
    output logic [NUM_CHN-1:0]            overrun_o,
    output logic [NUM_CHN-1:0]            stale_o,
    input  logic [NUM_CHN-1:0]            ovr_clr_i
);

    localparam int unsigned            WDOG_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDOG_WIDTH-1:0]  WDOG_MAX   = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CHN_WIDTH-1:0]   LAST_CHN   = CHN_WIDTH'(NUM_CHN - 1);

    logic [DATA_WIDTH-1:0] rpm_arr [NUM_CHN];

    logic [DATA_WIDTH-1:0] fdb_q  [NUM_CHN];
    logic [DATA_WIDTH-1:0] fdb_d  [NUM_CHN];
    logic [DATA_WIDTH-1:0] ref_q  [NUM_CHN];
    logic [DATA_WIDTH-1:0] ref_d  [NUM_CHN];
    logic [WDOG_WIDTH-1:0] wdog_q [NUM_CHN];
    logic [WDOG_WIDTH-1:0] wdog_d [NUM_CHN];
    logic [NUM_CHN-1:0]    pend_q, pend_d;
    logic [NUM_CHN-1:0]    ovr_q, ovr_d;
    logic [NUM_CHN-1:0]    stale_q, stale_d;
    logic [CHN_WIDTH-1:0]  ptr_q, ptr_d;

    logic                  valid_q, valid_d;
    logic [CHN_WIDTH-1:0]  chn_q, chn_d;
    logic [DATA_WIDTH-1:0] ofdb_q, ofdb_d;
    logic [DATA_WIDTH-1:0] oref_q, oref_d;

    logic [NUM_CHN-1:0]    gnt_oh;
    logic [CHN_WIDTH-1:0]  gnt_idx;
    logic                  gnt_any;
    logic                  load;
    logic [NUM_CHN-1:0]    grant;

    // Unflatten the feedback bus into one word per channel.
    for (genvar k = 0; k < NUM_CHN; k++) begin : g_unflat
        assign rpm_arr[k] = rpm_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    pid_chn_scheduler_rr_arbiter #(
        .N         (NUM_CHN)
    ) u_arb (
        .req_i     (pend_q & chn_en_i),
        .ptr_i     (ptr_q),
        .gnt_oh_c  (gnt_oh),
        .gnt_idx_c (gnt_idx),
        .gnt_any_c (gnt_any)
    );

    // The output register accepts a new beat when empty or being consumed.
    assign load  = !valid_q || tready_i;
    assign grant = load ? gnt_oh : '0;

    // Per-channel capture, setpoint, overrun and watchdog state.
    always_comb begin
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        stale_d = stale_q;
        for (int k = 0; k < NUM_CHN; k++) begin
            fdb_d[k]  = fdb_q[k];
            ref_d[k]  = ref_q[k];
            wdog_d[k] = wdog_q[k];

            // Out-of-range channel numbers match no k and are dropped.
            if (tr_valid_i && (tr_chn_i == CHN_WIDTH'(k))) begin
                ref_d[k] = tr_data_i;
            end

            if (rpm_valid_i[k]) begin
                // A fresh sample keeps pend set even if the old one is granted now.
                fdb_d[k]   = rpm_arr[k];
                pend_d[k]  = 1'b1;
                wdog_d[k]  = '0;
                stale_d[k] = 1'b0;
            end else begin
                if (grant[k]) begin
                    pend_d[k] = 1'b0;
                end
                if (wdog_q[k] != WDOG_MAX) begin
                    wdog_d[k] = wdog_q[k] + WDOG_WIDTH'(1);
                end
                if (wdog_d[k] == WDOG_MAX) begin
                    stale_d[k] = 1'b1;
                end
            end

            // Set wins over a simultaneous clear.
            if (ovr_clr_i[k]) begin
                ovr_d[k] = 1'b0;
            end
            if (rpm_valid_i[k] && pend_q[k] && !grant[k]) begin
                ovr_d[k] = 1'b1;
            end
        end
    end

    // Output beat selection and round-robin pointer advance.
    always_comb begin
        valid_d = valid_q;
        chn_d   = chn_q;
        ofdb_d  = ofdb_q;
        oref_d  = oref_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = gnt_any;
            if (gnt_any) begin
                chn_d  = gnt_idx;
                ofdb_d = fdb_q[gnt_idx];
                oref_d = stale_q[gnt_idx] ? '0 : ref_q[gnt_idx];
                ptr_d  = (gnt_idx == LAST_CHN) ? '0 : gnt_idx + CHN_WIDTH'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_CHN; k++) begin
                fdb_q[k]  <= '0;
                ref_q[k]  <= '0;
                wdog_q[k] <= '0;
            end
            pend_q  <= '0;
            ovr_q   <= '0;
            stale_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            chn_q   <= '0;
            ofdb_q  <= '0;
            oref_q  <= '0;
        end else begin
            fdb_q   <= fdb_d;
            ref_q   <= ref_d;
            wdog_q  <= wdog_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            stale_q <= stale_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            chn_q   <= chn_d;
            ofdb_q  <= ofdb_d;
            oref_q  <= oref_d;
        end
    end

    assign data_valid_o = valid_q;
    assign data_chn_o   = chn_q;
    assign data_fdb_o   = ofdb_q;
    assign data_ref_o   = oref_q;
    assign overrun_o    = ovr_q;
    assign stale_o      = stale_q;

endmodule

// File: tb/tb_pid_chn_scheduler.sv
// Randomised and directed bench for pid_chn_scheduler against a behavioural model.
module tb_pid_chn_scheduler;

    localparam int unsigned N  = 5;
    localparam int unsigned DW = 16;
    localparam int unsigned TO = 16;
    localparam int unsigned CW = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [N-1:0]      rpm_valid_i;
    logic [N*DW-1:0]   rpm_data_i;
    logic              tr_valid_i;
    logic [CW-1:0]     tr_chn_i;
    logic [DW-1:0]     tr_data_i;
    logic [N-1:0]      chn_en_i;
    logic              tready_i;
    logic              data_valid_o;
    logic [CW-1:0]     data_chn_o;
    logic [DW-1:0]     data_fdb_o;
    logic [DW-1:0]     data_ref_o;
    logic [N-1:0]      overrun_o;
    logic [N-1:0]      stale_o;
    logic [N-1:0]      ovr_clr_i;

    always #5 clk = ~clk;

    pid_chn_scheduler #(
        .NUM_CHN        (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .rpm_valid_i  (rpm_valid_i),
        .rpm_data_i   (rpm_data_i),
        .tr_valid_i   (tr_valid_i),
        .tr_chn_i     (tr_chn_i),
        .tr_data_i    (tr_data_i),
        .chn_en_i     (chn_en_i),
        .tready_i     (tready_i),
        .data_valid_o (data_valid_o),
        .data_chn_o   (data_chn_o),
        .data_fdb_o   (data_fdb_o),
        .data_ref_o   (data_ref_o),
        .overrun_o    (overrun_o),
        .stale_o      (stale_o),
        .ovr_clr_i    (ovr_clr_i)
    );

    // Reference model: per-channel sample/setpoint store, pending flags, age since last sample.
    int unsigned m_fdb [N];
    int unsigned m_ref [N];
    int unsigned m_age [N];
    logic [N-1:0] m_pend;
    logic [N-1:0] m_ovr;
    int unsigned  m_ptr;
    logic         e_valid;
    int unsigned  e_chn, e_fdb, e_ref;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_fdb[k] = 0;
            m_ref[k] = 0;
            m_age[k] = 0;
        end
        m_pend  = '0;
        m_ovr   = '0;
        m_ptr   = 0;
        e_valid = 1'b0;
        e_chn   = 0;
        e_fdb   = 0;
        e_ref   = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_step();
        int g;
        int c;
        bit ld;
        ld = !e_valid || tready_i;
        g  = -1;
        if (ld) begin
            for (int off = 0; off < int'(N); off++) begin
                c = (int'(m_ptr) + off) % int'(N);
                if (g < 0 && m_pend[c] && chn_en_i[c]) g = c;
            end
            e_valid = (g >= 0);
            if (g >= 0) begin
                e_chn = g;
                e_fdb = m_fdb[g];
                e_ref = (m_age[g] == TO - 1) ? 0 : m_ref[g];
                m_ptr = (g + 1) % int'(N);
            end
        end
        if (tr_valid_i && (int'(tr_chn_i) < int'(N))) m_ref[tr_chn_i] = 32'(tr_data_i);
        for (int k = 0; k < int'(N); k++) begin
            if (ovr_clr_i[k]) m_ovr[k] = 1'b0;
            if (rpm_valid_i[k]) begin
                if (m_pend[k] && g != k) m_ovr[k] = 1'b1;
                m_pend[k] = 1'b1;
                m_fdb[k]  = 32'(rpm_data_i[k*DW +: DW]);
                m_age[k]  = 0;
            end else begin
                if (g == k) m_pend[k] = 1'b0;
                if (m_age[k] < TO - 1) m_age[k]++;
            end
        end
    endtask

    task automatic check_all();
        logic [N-1:0] st;
        for (int k = 0; k < int'(N); k++) st[k] = (m_age[k] == TO - 1);
        chk("valid",   32'(data_valid_o), 32'(e_valid));
        chk("chn",     32'(data_chn_o),   e_chn);
        chk("fdb",     32'(data_fdb_o),   e_fdb);
        chk("ref",     32'(data_ref_o),   e_ref);
        chk("overrun", 32'(overrun_o),    32'(m_ovr));
        chk("stale",   32'(stale_o),      32'(st));
    endtask

    task automatic idle();
        rpm_valid_i = '0;
        tr_valid_i  = 1'b0;
        ovr_clr_i   = '0;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_inputs();
        for (int k = 0; k < int'(N); k++) begin
            rpm_valid_i[k]          = ($urandom_range(0, 5) == 0);
            rpm_data_i[k*DW +: DW]  = 16'($urandom);
            chn_en_i[k]             = ($urandom_range(0, 9) != 0);
            ovr_clr_i[k]            = ($urandom_range(0, 19) == 0);
        end
        tr_valid_i = ($urandom_range(0, 2) == 0);
        tr_chn_i   = 3'($urandom_range(0, 7));
        tr_data_i  = 16'($urandom);
        tready_i   = ($urandom_range(0, 3) != 0);
    endtask

    // Asynchronous reset away from the clock edge while traffic is pending.
    task automatic mid_reset();
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_valid",   32'(data_valid_o), 32'd0);
        chk("rst_async_overrun", 32'(overrun_o),    32'd0);
        chk("rst_async_stale",   32'(stale_o),      32'd0);
        model_reset();
        idle();
        @(negedge clk);
        check_all();
        rstn = 1'b1;
        repeat (4) begin
            step();
            chk("post_rst_quiet", 32'(data_valid_o), 32'd0);
        end
    endtask

    int exp_rr [5] = '{3, 4, 0, 1, 2};

    initial begin
        rstn        = 1'b0;
        rpm_data_i  = '0;
        tr_chn_i    = '0;
        tr_data_i   = '0;
        chn_en_i    = '1;
        tready_i    = 1'b1;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        check_all();
        rstn = 1'b1;

        // Single sample on channel 2 with a programmed setpoint.
        idle(); tr_valid_i = 1'b1; tr_chn_i = 3'd2; tr_data_i = 16'h0100; step();
        idle(); rpm_valid_i[2] = 1'b1; rpm_data_i[2*DW +: DW] = 16'h00F0; step();
        chk("single_t1_valid", 32'(data_valid_o), 32'd0);
        idle(); step();
        chk("single_valid", 32'(data_valid_o), 32'd1);
        chk("single_chn",   32'(data_chn_o),   32'd2);
        chk("single_fdb",   32'(data_fdb_o),   32'h00F0);
        chk("single_ref",   32'(data_ref_o),   32'h0100);

        // All channels at once: order starts after the last grant (ch2).
        idle(); rpm_valid_i = '1;
        for (int k = 0; k < int'(N); k++) rpm_data_i[k*DW +: DW] = 16'(16'h1000 + k);
        step();
        for (int i = 0; i < 5; i++) begin
            idle(); step();
            chk("rr_seq", 32'(data_chn_o), 32'(exp_rr[i]));
        end

        // Backpressure: payload frozen, repeat sample flags overrun, then clear.
        idle(); tready_i = 1'b0; rpm_valid_i[0] = 1'b1; rpm_data_i[0 +: DW] = 16'h2222; step();
        repeat (4) begin
            idle(); step();
            chk("bp_hold_valid", 32'(data_valid_o), 32'd1);
            chk("bp_hold_chn",   32'(data_chn_o),   32'd2);
            chk("bp_hold_fdb",   32'(data_fdb_o),   32'h1002);
        end
        idle(); rpm_valid_i[0] = 1'b1; rpm_data_i[0 +: DW] = 16'h3333; step();
        chk("ovr_set", 32'(overrun_o[0]), 32'd1);
        idle(); ovr_clr_i[0] = 1'b1; step();
        chk("ovr_clr", 32'(overrun_o[0]), 32'd0);
        idle(); tready_i = 1'b1;
        repeat (3) step();

        // Disabled channel goes stale while pending, then issues with ref forced to 0.
        idle(); tr_valid_i = 1'b1; tr_chn_i = 3'd1; tr_data_i = 16'h0ABC;
        rpm_valid_i[1] = 1'b1; rpm_data_i[1*DW +: DW] = 16'h0555; chn_en_i = 5'b11101; step();
        repeat (16) begin
            idle(); step();
            chk("en_block", 32'(data_valid_o), 32'd0);
        end
        chk("stale_set", 32'(stale_o[1]), 32'd1);
        idle(); chn_en_i = '1; step();
        chk("stale_issue_chn", 32'(data_chn_o), 32'd1);
        chk("stale_issue_fdb", 32'(data_fdb_o), 32'h0555);
        chk("stale_issue_ref", 32'(data_ref_o), 32'd0);
        idle(); rpm_valid_i[1] = 1'b1; rpm_data_i[1*DW +: DW] = 16'h0666; step();
        chk("stale_clr", 32'(stale_o[1]), 32'd0);

        // Out-of-range setpoint write leaves every ref untouched.
        idle(); tr_valid_i = 1'b1; tr_chn_i = 3'd5; tr_data_i = 16'h7777; step();
        idle(); rpm_valid_i[1] = 1'b1; step();
        idle(); step();
        chk("range_ref", 32'(data_ref_o), 32'h0ABC);

        repeat (3000) begin
            rand_inputs();
            step();
        end

        idle(); rpm_valid_i = '1; tready_i = 1'b0; step();
        mid_reset();

        repeat (500) begin
            rand_inputs();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
